boton_eventos: RTL and testbench
================================

# boton_eventos

Button gesture decoder that consumes the clean, active-high level from the push-button debouncer and turns it into one-cycle event pulses for the pet state logic. It classifies each press as short, when released before a hold threshold, or long, when held past the threshold. While a long press is held it emits periodic auto-repeat pulses. One instance sits behind each debounced button, between the debouncer and the menu/feeding/sleep control FSM.

## Interface

Parameters:
- LARGO_CICLOS, default 100000000: sampled-high cycles that make a press long (2 s at 50 MHz). Must be ≥ 2.
- REPETIR_CICLOS, default 25000000: cycles between auto-repeat pulses during a long hold. 0 disables repeat.
- ANCHO_CONT, default 27: counter width. Must hold max(LARGO_CICLOS, REPETIR_CICLOS) − 1.

Ports:
- clk, input, 1: system clock. The only clock.
- rst, input, 1: asynchronous, active-low reset.
- boton_limpio, input, 1: debounced level, 1 = pressed. Synchronous to clk.
- presionado, output, 1: registered level, 1 while in PRESIONADO or LARGO.
- pulso_corto, output, 1: one-cycle pulse, short press completed.
- pulso_largo, output, 1: one-cycle pulse, hold reached LARGO_CICLOS.
- pulso_repeticion, output, 1: one-cycle pulse, auto-repeat during a long hold.

## Operation

- All outputs are registered.
- Reset (rst = 0, asynchronous): state = ESPERA_SUELTA, cont = 0, all four outputs 0.
- States: ESPERA_SUELTA, REPOSO, PRESIONADO, LARGO.
- ESPERA_SUELTA: waits for a release, so a button held through reset is never decoded.
  - boton_limpio = 0 → REPOSO.
  - Otherwise stay.
- REPOSO:
  - boton_limpio = 1 → PRESIONADO, cont ← 1.
  - Otherwise stay.
- PRESIONADO:
  - boton_limpio = 0 → REPOSO, cont ← 0, pulso_corto ← 1.
  - Else if cont == LARGO_CICLOS − 1 → LARGO, cont ← 0, pulso_largo ← 1.
  - Else cont ← cont + 1.
- LARGO:
  - boton_limpio = 0 → REPOSO, cont ← 0, no pulse.
  - Else if REPETIR_CICLOS ≠ 0 and cont == REPETIR_CICLOS − 1 → cont ← 0, pulso_repeticion ← 1.
  - Else if REPETIR_CICLOS ≠ 0, cont ← cont + 1.
  - If REPETIR_CICLOS = 0, cont holds at 0.
- Pulse outputs default to 0 every cycle unless set by the rules above.
- Event rules:
  - At most one pulse output is high in any cycle.
  - pulso_corto and pulso_largo are mutually exclusive per press.
  - A long press never produces pulso_corto.
- Release takes priority over a coincident threshold or repeat. On the edge that samples 0, no pulso_largo or pulso_repeticion is produced.
- cont never wraps. It resets to 0 before reaching its terminal value + 1.

## Timing

- Latency: each event output rises on the clock edge that samples the deciding input value. The pulse is visible for the following cycle.
- pulso_corto: high for the cycle after the first edge that samples boton_limpio = 0, provided the input was high for 1 to LARGO_CICLOS − 1 sampled edges.
- pulso_largo: high after the LARGO_CICLOS-th consecutive edge sampling 1.
- pulso_repeticion: first pulse comes REPETIR_CICLOS edges after the pulso_largo edge, then every REPETIR_CICLOS edges.
- presionado: rises one cycle after the first sampled 1 and falls one cycle after the first sampled 0. It remains 0 in ESPERA_SUELTA.
- Minimum press: a single-cycle high input yields pulso_corto.
- Back-to-back presses:
  - A 0 followed by a 1 on the next edge starts a new press directly.
  - The REPOSO → PRESIONADO transition takes one edge.
- Reset mid-operation: outputs drop to 0 asynchronously, including a pulse in flight. No event is emitted on exit from reset.

## Test plan

Bench parameters: LARGO_CICLOS = 8, REPETIR_CICLOS = 4. Bench starts with rst released and boton_limpio = 0 for 2 cycles.

- Short press: boton_limpio high for 3 edges, then low.
  - Exactly one pulso_corto, one cycle wide, after the first low-sampling edge.
  - presionado high for 3 cycles.
  - No pulso_largo.
- Threshold boundary:
  - 7 high edges, then low → pulso_corto only.
  - 8 high edges, then low → pulso_largo after the 8th edge, no pulso_corto on release.
- Auto-repeat: hold 20 edges.
  - pulso_largo after edge 8.
  - pulso_repeticion after edges 12, 16, 20.
  - Release on edge 21 → no further pulses, presionado falls.
- Release coincident with a repeat: hold 15 edges, low on edge 16.
  - pulso_repeticion after edge 12 only.
  - Nothing at edge 16.
- Held through reset: boton_limpio = 1 while rst deasserts, held 20 edges, then released.
  - All outputs stay 0 throughout.
  - A subsequent 2-edge press gives pulso_corto.
- Async reset mid-hold: assert rst between clock edges at hold edge 10.
  - All outputs go 0 immediately.
  - After release from reset with input low, a fresh 3-edge press gives a normal pulso_corto.
- Rerun the auto-repeat scenario with REPETIR_CICLOS = 0: pulso_largo only, zero pulso_repeticion.

Source files
------------

// File: rtl/boton_eventos.sv
// boton_eventos
// Button gesture decoder. Turns the debounced push-button level into
// one-cycle event pulses: short press, long press, and auto-repeat while
// a long press is held.
//
// Ports:
//   clk              system clock
//   rst              asynchronous reset, active low
//   boton_limpio     debounced button level, 1 = pressed
//   presionado       registered level, 1 while a press is being tracked
//   pulso_corto      one-cycle pulse, press released before the hold threshold
//   pulso_largo      one-cycle pulse, hold reached LARGO_CICLOS
//   pulso_repeticion one-cycle pulse, periodic auto-repeat during a long hold
//
// state         | meaning
// --------------+---------------------------------------------------------
// ESPERA_SUELTA | after reset, wait for a release so a held button is ignored
// REPOSO        | idle, button released
// PRESIONADO    | pressed, counting toward the long-press threshold
// LARGO         | long press held, counting auto-repeat periods
module boton_eventos #(
    parameter int LARGO_CICLOS   = 100000000,
    parameter int REPETIR_CICLOS = 25000000,
    parameter int ANCHO_CONT     = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic boton_limpio,
    output logic presionado,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic pulso_repeticion
);

    typedef enum logic [1:0] {
        ESPERA_SUELTA,
        REPOSO,
        PRESIONADO,
        LARGO
    } estado_t;

    localparam logic [ANCHO_CONT-1:0] FIN_LARGO = ANCHO_CONT'(LARGO_CICLOS - 1);
    // Repeat terminal count is only meaningful when repeat is enabled.
    localparam logic [ANCHO_CONT-1:0] FIN_REP   =
        ANCHO_CONT'((REPETIR_CICLOS > 0) ? (REPETIR_CICLOS - 1) : 0);
    localparam logic                  REP_ON    = (REPETIR_CICLOS != 0);
    localparam logic [ANCHO_CONT-1:0] UNO       = ANCHO_CONT'(1);
    localparam logic [ANCHO_CONT-1:0] CERO      = '0;

    estado_t               estado_q, estado_d;
    logic [ANCHO_CONT-1:0] cont_q, cont_d;
    logic                  presionado_q, presionado_d;
    logic                  corto_q, corto_d;
    logic                  largo_q, largo_d;
    logic                  rep_q, rep_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q     <= ESPERA_SUELTA;
            cont_q       <= CERO;
            presionado_q <= 1'b0;
            corto_q      <= 1'b0;
            largo_q      <= 1'b0;
            rep_q        <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cont_q       <= cont_d;
            presionado_q <= presionado_d;
            corto_q      <= corto_d;
            largo_q      <= largo_d;
            rep_q        <= rep_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        corto_d  = 1'b0;
        largo_d  = 1'b0;
        rep_d    = 1'b0;

        unique case (estado_q)
            ESPERA_SUELTA: begin
                if (!boton_limpio) begin
                    estado_d = REPOSO;
                end
            end
            REPOSO: begin
                if (boton_limpio) begin
                    estado_d = PRESIONADO;
                    cont_d   = UNO;
                end
            end
            PRESIONADO: begin
                // Release wins over a coincident threshold.
                if (!boton_limpio) begin
                    estado_d = REPOSO;
                    cont_d   = CERO;
                    corto_d  = 1'b1;
                end else if (cont_q == FIN_LARGO) begin
                    estado_d = LARGO;
                    cont_d   = CERO;
                    largo_d  = 1'b1;
                end else begin
                    cont_d   = cont_q + UNO;
                end
            end
            LARGO: begin
                if (!boton_limpio) begin
                    estado_d = REPOSO;
                    cont_d   = CERO;
                end else if (REP_ON && (cont_q == FIN_REP)) begin
                    cont_d   = CERO;
                    rep_d    = 1'b1;
                end else if (REP_ON) begin
                    cont_d   = cont_q + UNO;
                end else begin
                    cont_d   = CERO;
                end
            end
            default: begin
                estado_d = ESPERA_SUELTA;
                cont_d   = CERO;
            end
        endcase

        presionado_d = (estado_d == PRESIONADO) || (estado_d == LARGO);
    end

    assign presionado       = presionado_q;
    assign pulso_corto      = corto_q;
    assign pulso_largo      = largo_q;
    assign pulso_repeticion = rep_q;

endmodule

// File: tb/tb_boton_eventos.sv
// tb_boton_eventos
// Drives two decoders from the same stimulus: one with auto-repeat every
// 4 cycles and one with repeat disabled, both with an 8-cycle long-press
// threshold. Expected pulses are queued with the clock edge after which
// they must appear; a monitor per instance pops and compares.
module tb_boton_eventos;

    localparam int K_CORTO = 1;
    localparam int K_LARGO = 2;
    localparam int K_REP   = 3;

    typedef struct {
        int kind;
        int edge_no;
    } ev_t;

    logic clk;
    logic rst;
    logic boton;
    logic pres0, pc0, pl0, pr0;
    logic pres1, pc1, pl1, pr1;

    int edge_n = 0;
    int n_chk  = 0;
    int n_fail = 0;

    ev_t q0[$];
    ev_t q1[$];

    boton_eventos #(
        .LARGO_CICLOS  (8),
        .REPETIR_CICLOS(4),
        .ANCHO_CONT    (4)
    ) dut_rep (
        .clk             (clk),
        .rst             (rst),
        .boton_limpio    (boton),
        .presionado      (pres0),
        .pulso_corto     (pc0),
        .pulso_largo     (pl0),
        .pulso_repeticion(pr0)
    );

    boton_eventos #(
        .LARGO_CICLOS  (8),
        .REPETIR_CICLOS(0),
        .ANCHO_CONT    (4)
    ) dut_norep (
        .clk             (clk),
        .rst             (rst),
        .boton_limpio    (boton),
        .presionado      (pres1),
        .pulso_corto     (pc1),
        .pulso_largo     (pl1),
        .pulso_repeticion(pr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input int inst, input int kind, input int e);
        ev_t ev;
        ev.kind    = kind;
        ev.edge_no = e;
        if (inst == 0) q0.push_back(ev);
        else           q1.push_back(ev);
    endtask

    task automatic see(input int inst, input logic c, input logic l, input logic r);
        ev_t ev;
        int  kind;
        if (!(c || l || r)) return;
        chk(inst == 0 ? "one_pulse_rep" : "one_pulse_norep", int'(c) + int'(l) + int'(r), 1);
        kind = c ? K_CORTO : (l ? K_LARGO : K_REP);
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            chk(inst == 0 ? "unexpected_pulse_rep" : "unexpected_pulse_norep", kind, 0);
        end else begin
            ev = (inst == 0) ? q0.pop_front() : q1.pop_front();
            chk(inst == 0 ? "kind_rep" : "kind_norep", kind, ev.kind);
            chk(inst == 0 ? "edge_rep" : "edge_norep", edge_n, ev.edge_no);
        end
    endtask

    // Outputs are registered on posedge; sample on the opposite edge.
    always @(negedge clk) see(0, pc0, pl0, pr0);
    always @(negedge clk) see(1, pc1, pl1, pr1);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_pres(input string name, input int exp);
        chk(name, int'(pres0), exp);
        chk(name, int'(pres1), exp);
    endtask

    // Hold the button for n sampled edges, then release and idle two cycles.
    task automatic press(input int n);
        int e0;
        e0 = edge_n;
        if (n <= 7) begin
            push(0, K_CORTO, e0 + n + 1);
            push(1, K_CORTO, e0 + n + 1);
        end else begin
            push(0, K_LARGO, e0 + 8);
            push(1, K_LARGO, e0 + 8);
            for (int t = e0 + 12; t <= e0 + n; t += 4) push(0, K_REP, t);
        end
        boton = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_pres("presionado_hold", 1);
        end
        boton = 1'b0;
        tick();
        chk_pres("presionado_release", 0);
        repeat (2) tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({pres0, pc0, pl0, pr0}), 0);
        chk(name, int'({pres1, pc1, pl1, pr1}), 0);
    endtask

    initial begin
        int e0;
        rst   = 1'b0;
        boton = 1'b0;
        #12;
        chk_all_zero("reset_state");
        tick();
        rst = 1'b1;
        repeat (2) tick();
        chk_all_zero("idle_after_reset");

        press(3);
        press(7);
        press(8);
        press(20);
        press(15);

        // Button held straight through reset must never be decoded.
        rst   = 1'b0;
        boton = 1'b1;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_pres("held_through_reset", 0);
        end
        boton = 1'b0;
        repeat (2) tick();
        press(2);

        // Async reset in the middle of a long hold.
        e0 = edge_n;
        push(0, K_LARGO, e0 + 8);
        push(1, K_LARGO, e0 + 8);
        boton = 1'b1;
        repeat (9) tick();
        @(posedge clk);
        #2;
        chk_pres("pres_before_async_rst", 1);
        rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        boton = 1'b0;
        repeat (2) tick();
        chk_all_zero("held_in_reset");
        rst = 1'b1;
        repeat (2) tick();
        press(3);

        repeat (4) tick();
        chk("q_rep_drained", q0.size(), 0);
        chk("q_norep_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
